// File: rtl/maze_pkg.sv
// Shared types and defaults for the MazeRunner command link.
package maze_pkg;

  typedef enum logic { RX_HIGH, RX_LOW  } rx_state_t;
  typedef enum logic { TX_IDLE, TX_BUSY } tx_state_t;

  localparam logic [7:0] RESP_ACK     = 8'hA5;
  localparam int         BAUD_DIV_DEF = 2604;       // 50 MHz / 19200
  localparam int         TIMEOUT_DEF  = 1_000_000;  // high byte -> low byte limit
  localparam int         TMR_W        = 20;

endpackage

// File: rtl/uart_cmd_wrapper_uart.sv
// 8N1 UART transceiver: rx_rdy/clr_rx_rdy/rx_data receive side,
// trmt/tx_data/tx_done transmit side. LSB first, one stop bit.
module uart_cmd_wrapper_uart
  import maze_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic       tx_o,
  output logic       rx_rdy_o,
  input  logic       clr_rx_rdy_i,
  output logic [7:0] rx_data_o,
  input  logic       trmt_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_done_o
);

  localparam int            CW   = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2);

  logic          rx_s1_q, rx_s2_q, rx_busy_q, rx_rdy_q;
  logic [CW-1:0] rx_cnt_q;
  logic [3:0]    rx_bit_q;
  logic [7:0]    rx_sh_q;

  logic          tx_busy_q, tx_done_q;
  logic [CW-1:0] tx_cnt_q;
  logic [3:0]    tx_bit_q;
  logic [9:0]    tx_sh_q;

  // Receiver: sample each bit at its centre; bit 0 is start, 1..8 data, 9 stop.
  // A new start bit retires any unread byte so rx_data never changes under rx_rdy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_busy_q <= 1'b0;
      rx_rdy_q  <= 1'b0;
      rx_cnt_q  <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
    end else begin
      rx_s1_q <= rx_i;
      rx_s2_q <= rx_s1_q;
      if (clr_rx_rdy_i) rx_rdy_q <= 1'b0;
      if (!rx_busy_q) begin
        if (!rx_s2_q) begin
          rx_busy_q <= 1'b1;
          rx_cnt_q  <= HALF;
          rx_bit_q  <= '0;
          rx_rdy_q  <= 1'b0;
        end
      end else if (rx_cnt_q == '0) begin
        rx_cnt_q <= FULL;
        if (rx_bit_q == 4'd9) begin
          rx_busy_q <= 1'b0;
          rx_rdy_q  <= 1'b1;
        end else begin
          if (rx_bit_q != 4'd0) rx_sh_q <= {rx_s2_q, rx_sh_q[7:1]};
          rx_bit_q <= rx_bit_q + 4'd1;
        end
      end else begin
        rx_cnt_q <= rx_cnt_q - 1'b1;
      end
    end
  end

  // Transmitter: shift {stop, data, start} out LSB first; tx_done pulses once
  // the stop bit has been held for a full bit time.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_sh_q   <= '1;
      tx_busy_q <= 1'b0;
      tx_done_q <= 1'b0;
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
    end else begin
      tx_done_q <= 1'b0;
      if (!tx_busy_q) begin
        if (trmt_i) begin
          tx_sh_q   <= {1'b1, tx_data_i, 1'b0};
          tx_busy_q <= 1'b1;
          tx_cnt_q  <= FULL;
          tx_bit_q  <= '0;
        end
      end else if (tx_cnt_q == '0) begin
        tx_cnt_q <= FULL;
        if (tx_bit_q == 4'd9) begin
          tx_busy_q <= 1'b0;
          tx_done_q <= 1'b1;
        end else begin
          tx_sh_q  <= {1'b1, tx_sh_q[9:1]};
          tx_bit_q <= tx_bit_q + 4'd1;
        end
      end else begin
        tx_cnt_q <= tx_cnt_q - 1'b1;
      end
    end
  end

  assign tx_o      = tx_sh_q[0];
  assign rx_rdy_o  = rx_rdy_q;
  assign rx_data_o = rx_sh_q;
  assign tx_done_o = tx_done_q;

endmodule

// File: rtl/uart_cmd_wrapper.sv
// MazeRunner command link receive wrapper: two UART bytes (high first) form a
// 16-bit cmd held under cmd_rdy; single-byte responses go back over TX.
module uart_cmd_wrapper
  import maze_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        snd_resp,
  output logic        resp_sent,
  output logic        cmd_err
);

  localparam logic [TMR_W-1:0] TO_M1 = TMR_W'(TIMEOUT - 1);

  logic             rx_rdy, clr_rx_rdy, trmt_q, tx_done;
  logic [7:0]       rx_data, tx_data_q;

  rx_state_t        rx_state_q;
  logic [15:0]      cmd_q;
  logic             cmd_rdy_q, cmd_err_q;
  logic [TMR_W-1:0] timer_q, timer_d;

  tx_state_t        tx_state_q;
  logic             pend_vld_q, resp_sent_q;
  logic [7:0]       pend_q;

  uart_cmd_wrapper_uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_i         (RX),
    .tx_o         (TX),
    .rx_rdy_o     (rx_rdy),
    .clr_rx_rdy_i (clr_rx_rdy),
    .rx_data_o    (rx_data),
    .trmt_i       (trmt_q),
    .tx_data_i    (tx_data_q),
    .tx_done_o    (tx_done)
  );

  // Every received byte is consumed the cycle it appears, in either RX state.
  assign clr_rx_rdy = rx_rdy;
  assign timer_d    = (timer_q == '1) ? timer_q : timer_q + 1'b1;

  // Command assembly FSM: high byte, then low byte within TIMEOUT cycles.
  // A byte arriving on the timeout cycle takes priority over the error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state_q <= RX_HIGH;
      cmd_q      <= '0;
      cmd_rdy_q  <= 1'b0;
      cmd_err_q  <= 1'b0;
      timer_q    <= '0;
    end else begin
      cmd_err_q <= 1'b0;
      if (clr_cmd_rdy) cmd_rdy_q <= 1'b0;
      case (rx_state_q)
        RX_HIGH: if (rx_rdy) begin
          cmd_q[15:8] <= rx_data;
          cmd_rdy_q   <= 1'b0;
          timer_q     <= '0;
          rx_state_q  <= RX_LOW;
        end
        RX_LOW: if (rx_rdy) begin
          cmd_q[7:0] <= rx_data;
          cmd_rdy_q  <= 1'b1;
          rx_state_q <= RX_HIGH;
        end else if (timer_q == TO_M1) begin
          cmd_err_q  <= 1'b1;
          rx_state_q <= RX_HIGH;
        end else begin
          timer_q <= timer_d;
        end
      endcase
    end
  end

  // Response FSM: one byte in flight plus a 1-deep pending slot (last request
  // wins). A fresh request in TX_IDLE supersedes an older pending byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_q  <= TX_IDLE;
      trmt_q      <= 1'b0;
      tx_data_q   <= '0;
      pend_vld_q  <= 1'b0;
      pend_q      <= '0;
      resp_sent_q <= 1'b0;
    end else begin
      trmt_q      <= 1'b0;
      resp_sent_q <= 1'b0;
      case (tx_state_q)
        TX_IDLE: if (snd_resp) begin
          trmt_q     <= 1'b1;
          tx_data_q  <= resp;
          pend_vld_q <= 1'b0;
          tx_state_q <= TX_BUSY;
        end else if (pend_vld_q) begin
          trmt_q     <= 1'b1;
          tx_data_q  <= pend_q;
          pend_vld_q <= 1'b0;
          tx_state_q <= TX_BUSY;
        end
        TX_BUSY: begin
          if (snd_resp) begin
            pend_q     <= resp;
            pend_vld_q <= 1'b1;
          end
          if (tx_done) begin
            resp_sent_q <= 1'b1;
            tx_state_q  <= TX_IDLE;
          end
        end
      endcase
    end
  end

  assign cmd       = cmd_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign cmd_err   = cmd_err_q;
  assign resp_sent = resp_sent_q;

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Bench for uart_cmd_wrapper: a RemoteComm model drives RX serially and
// decodes TX; expected cmds/response bytes are queued at issue and checked
// by independent monitors.
module tb_uart_cmd_wrapper;

  localparam int BAUD    = 16;
  localparam int TIMEOUT = 4096;

  logic        clk = 1'b0;
  logic        rst_n, RX, TX, cmd_rdy, clr_cmd_rdy, snd_resp, resp_sent, cmd_err;
  logic [15:0] cmd;
  logic [7:0]  resp;

  int checks = 0, failures = 0;
  int rise_cnt = 0, err_cnt = 0, sent_cnt = 0, dec_cnt = 0;
  logic        rdy_prev = 1'b0;
  logic [7:0]  dec_b;
  logic [15:0] exp_cmd[$];
  logic [7:0]  exp_resp[$];

  uart_cmd_wrapper #(.BAUD_DIV(BAUD), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .snd_resp(snd_resp),
    .resp_sent(resp_sent), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BAUD) @(negedge clk);
    end
    RX = 1'b1;
    repeat (3 * BAUD) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [15:0] c);
    exp_cmd.push_back(c);
    send_byte(c[15:8]);
    send_byte(c[7:0]);
  endtask

  task automatic pulse_resp(input logic [7:0] r);
    resp = r; snd_resp = 1'b1;
    @(negedge clk);
    snd_resp = 1'b0;
  endtask

  task automatic wait_cmd(input string name);
    int n = 0;
    while (exp_cmd.size() != 0 && n < 1000) begin @(negedge clk); n++; end
    chk(name, exp_cmd.size(), 0);
  endtask

  task automatic wait_sent(input string name, input int target);
    int n = 0;
    while (sent_cnt < target && n < 2000) begin @(negedge clk); n++; end
    chk(name, (sent_cnt >= target), 1);
  endtask

  // Command / pulse monitor
  initial begin
    forever begin
      @(negedge clk);
      if (cmd_rdy === 1'b1 && rdy_prev === 1'b0) begin
        rise_cnt++;
        if (exp_cmd.size() == 0) begin
          checks++; failures++;
          $display("FAIL cmd_unexpected: got %0h expected none", cmd);
        end else chk("cmd_value", cmd, exp_cmd.pop_front());
      end
      rdy_prev = cmd_rdy;
      if (cmd_err === 1'b1) err_cnt++;
      if (resp_sent === 1'b1) sent_cnt++;
    end
  end

  // RemoteComm receive side: decode TX frames
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && TX === 1'b0) begin
        repeat (BAUD / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD) @(negedge clk);
          dec_b[i] = TX;
        end
        repeat (BAUD) @(negedge clk);
        chk("tx_stop", TX, 1);
        dec_cnt++;
        if (exp_resp.size() == 0) begin
          checks++; failures++;
          $display("FAIL tx_unexpected: got %0h expected none", dec_b);
        end else chk("tx_byte", dec_b, exp_resp.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0; RX = 1'b1; clr_cmd_rdy = 1'b0; resp = '0; snd_resp = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_cmd", cmd, 0);
    chk("rst_cmd_rdy", cmd_rdy, 0);
    chk("rst_tx", TX, 1);
    chk("rst_resp_sent", resp_sent, 0);
    chk("rst_cmd_err", cmd_err, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Full command
    send_cmd(16'h23FF);
    wait_cmd("cmd_23FF_seen");
    chk("rise_23FF", rise_cnt, 1);
    chk("err_23FF", err_cnt, 0);

    // Consumer clears cmd_rdy
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    chk("clr_cmd_rdy", cmd_rdy, 0);
    chk("clr_cmd_hold", cmd, 16'h23FF);

    // Lone high byte times out
    send_byte(8'h40);
    repeat (TIMEOUT + 200) @(negedge clk);
    chk("timeout_err", err_cnt, 1);
    chk("timeout_rdy", cmd_rdy, 0);
    chk("timeout_rise", rise_cnt, 1);

    send_cmd(16'h6000);
    wait_cmd("cmd_6000_seen");
    chk("err_6000", err_cnt, 1);

    // Single ack
    exp_resp.push_back(8'hA5);
    pulse_resp(8'hA5);
    wait_sent("sent_A5_wait", 1);
    repeat (3 * BAUD) @(negedge clk);
    chk("sent_A5_cnt", sent_cnt, 1);
    chk("resp_q_A5", exp_resp.size(), 0);

    // Back-to-back with overwrite of pending slot
    exp_resp.push_back(8'h11);
    exp_resp.push_back(8'hA5);
    pulse_resp(8'h11);
    repeat (20) @(negedge clk);
    pulse_resp(8'h22);
    repeat (10) @(negedge clk);
    pulse_resp(8'hA5);
    wait_sent("sent_b2b_wait", 3);
    repeat (3 * BAUD) @(negedge clk);
    chk("sent_b2b_cnt", sent_cnt, 3);
    chk("dec_b2b_cnt", dec_cnt, 3);
    chk("resp_q_b2b", exp_resp.size(), 0);

    // Reset in the middle of a high byte (cmd_rdy is still 1 from 6000)
    chk("pre_rst_rdy", cmd_rdy, 1);
    RX = 1'b0;
    repeat (3 * BAUD) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_tx", TX, 1);
    chk("midrst_rdy", cmd_rdy, 0);
    chk("midrst_cmd", cmd, 0);
    RX = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * BAUD) @(negedge clk);
    send_cmd(16'h4002);
    wait_cmd("cmd_4002_seen");
    chk("rise_final", rise_cnt, 3);
    chk("err_final", err_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
